// File: rtl/div32.sv
// div32 -- iterative unsigned restoring divider, one quotient bit per cycle,
// MSB first, WIDTH cycles of latency.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        request; accepted on an edge where start=1 and busy=0
//   dividend     unsigned numerator, sampled on the accept edge
//   divisor      unsigned denominator, sampled on the accept edge
//   busy         high while a division is in progress
//   done         one-cycle completion pulse
//   quotient     registered result, held until the next done
//   remainder    registered result, held until the next done
//   div_by_zero  registered flag: the divisor of the current result was 0
//   dbg_state    current FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: start acts as valid and !busy acts as ready. A request is taken
// on any rising edge where start=1 and busy=0. busy is low in the done cycle,
// so a new request can be taken on the same edge that ends the done pulse.
// start while busy=1 is ignored.
module div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   rem_q, rem_d;        // partial remainder
    logic [WIDTH-1:0]   work_q, work_d;      // dividend shifts out, quotient shifts in
    logic [WIDTH-1:0]   dvsr_q, dvsr_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remo_q, remo_d;
    logic               dbz_q, dbz_d;
    logic               done_q, done_d;

    // WIDTH+1-bit shifted partial remainder and the trial difference. The
    // difference only matters when partial >= divisor, in which case the
    // result is below the divisor and fits in WIDTH bits.
    logic [WIDTH:0]     partial;
    logic [WIDTH-1:0]   diff;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        work_d  = work_q;
        dvsr_d  = dvsr_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        done_d  = 1'b0;

        partial = {rem_q, work_q[WIDTH-1]};
        diff    = partial[WIDTH-1:0] - dvsr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    work_d  = dividend;
                    dvsr_d  = divisor;
                    rem_d   = '0;
                    count_d = CNT_W'(WIDTH);
                end
            end
            S_RUN: begin
                if (partial >= {1'b0, dvsr_q}) begin
                    rem_d  = diff;
                    work_d = {work_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = partial[WIDTH-1:0];
                    work_d = {work_q[WIDTH-2:0], 1'b0};
                end
                count_d = count_q - CNT_W'(1);
                // Last iteration: publish results from this step's values.
                if (count_q == CNT_W'(1)) begin
                    quot_d  = work_d;
                    remo_d  = rem_d;
                    dbz_d   = (dvsr_q == '0);
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            work_q  <= '0;
            dvsr_q  <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            work_q  <= work_d;
            dvsr_q  <= dvsr_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == S_RUN);
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule
